// File: rtl/iq_filter_pkg.sv
// Shared types and helpers for the multi-channel IQ FIR filter: FSM states,
// default low-pass taps and the shift/saturate step applied to each result.
package iq_filter_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  localparam int N_DEFAULT = 16;
  // Symmetric low-pass taps, sum = 128, so a SHIFT of 7 gives unity DC gain.
  localparam int COEF_DEFAULT [N_DEFAULT] = '{1, 2, 3, 5, 8, 11, 14, 20,
                                              20, 14, 11, 8, 5, 3, 2, 1};

  function automatic int coef_default(input int i);
    int r;
    r = 0;
    if (i >= 0 && i < N_DEFAULT) r = COEF_DEFAULT[i[3:0]];
    return r;
  endfunction

  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int shift, input int dw);
    logic signed [63:0] s, hi, lo, r;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (s > hi)      r = hi;
    else if (s < lo) r = lo;
    else             r = s;
    return r;
  endfunction

endpackage

// File: rtl/iq_fir_mac.sv
// Two-stage signed MAC: the product is registered, then added into the
// accumulator; the accumulator clears after the last term of each channel.
module iq_fir_mac #(
  parameter int DATA_W = 5,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 17
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     in_vld,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] c,
  output logic                     out_last,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [DATA_W+COEF_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic                            vld_q, vld_d, last_q, last_d;

  always_comb begin
    prod_d = x * c;
    vld_d  = in_vld;
    last_d = in_vld & in_last;
    sum    = acc_q + ACC_W'(prod_q);
    acc_d  = acc_q;
    if (clr)        acc_d = '0;
    else if (vld_q) acc_d = last_q ? '0 : sum;
    out_last = vld_q & last_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
      acc_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/iq_fir_filter.sv
// Multi-channel FIR low-pass: per-channel delay lines, one shared reloadable
// coefficient set and a single time-multiplexed MAC, with valid/ready output.
module iq_fir_filter
  import iq_filter_pkg::*;
#(
  parameter int DATA_W = 5,
  parameter int COEF_W = 8,
  parameter int N_TAPS = 16,
  parameter int N_CH   = 2,
  parameter int SHIFT  = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH*DATA_W-1:0]    data_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N_CH*DATA_W-1:0]    data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      coef_we,
  input  logic [$clog2(N_TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  output logic                      busy
);

  localparam int TW    = $clog2(N_TAPS);
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ACC_W = DATA_W + COEF_W + TW;

  function automatic logic [N_TAPS-1:0][COEF_W-1:0] coef_rst();
    logic [N_TAPS-1:0][COEF_W-1:0] r;
    for (int i = 0; i < N_TAPS; i++) r[i] = COEF_W'(coef_default(i));
    return r;
  endfunction

  localparam logic [N_TAPS-1:0][COEF_W-1:0] COEF_RST = coef_rst();

  state_e                                 state_q, state_d;
  logic [N_CH-1:0][N_TAPS-1:0][DATA_W-1:0] dl_q, dl_d;
  logic [N_TAPS-1:0][COEF_W-1:0]          coef_q, coef_d;
  logic [N_CH-1:0][DATA_W-1:0]            dout_q, dout_d;
  logic [TW-1:0]                          tap_q, tap_d;
  logic [CW-1:0]                          ch_q, ch_d, res_ch_q, res_ch_d;
  logic                                   issue_done_q, issue_done_d;

  logic                     accept, issue, issue_last, coef_wr, mac_last;
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [DATA_W-1:0] res;

  assign accept     = (state_q == IDLE) && in_valid;
  assign issue      = (state_q == MAC) && !issue_done_q;
  assign issue_last = issue && (tap_q == TW'(N_TAPS - 1));
  // A sample arriving in the same cycle takes priority over a write.
  assign coef_wr    = (state_q == IDLE) && coef_we && !in_valid &&
                      ({1'b0, coef_addr} < (TW + 1)'(N_TAPS));

  iq_fir_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .in_vld   (issue),
    .in_last  (issue_last),
    .x        ($signed(dl_q[ch_q][tap_q])),
    .c        ($signed(coef_q[tap_q])),
    .out_last (mac_last),
    .sum      (mac_sum)
  );

  assign res = DATA_W'(sat_shift(64'(mac_sum), SHIFT, DATA_W));

  always_comb begin
    state_d      = state_q;
    dl_d         = dl_q;
    coef_d       = coef_q;
    dout_d       = dout_q;
    tap_d        = tap_q;
    ch_d         = ch_q;
    res_ch_d     = res_ch_q;
    issue_done_d = issue_done_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int c = 0; c < N_CH; c++)
            dl_d[c] = {dl_q[c][N_TAPS-2:0], data_in[c*DATA_W +: DATA_W]};
          tap_d        = '0;
          ch_d         = '0;
          res_ch_d     = '0;
          issue_done_d = 1'b0;
          state_d      = MAC;
        end else if (coef_wr) begin
          coef_d[coef_addr] = coef_data;
        end
      end
      MAC: begin
        // Issue side walks taps/channels; result side trails by the MAC pipe.
        if (issue) begin
          if (issue_last) begin
            tap_d = '0;
            if (ch_q == CW'(N_CH - 1)) issue_done_d = 1'b1;
            else                       ch_d = ch_q + 1'b1;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
        if (mac_last) begin
          dout_d[res_ch_q] = res;
          if (res_ch_q == CW'(N_CH - 1)) state_d = OUT;
          else                           res_ch_d = res_ch_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dl_q         <= '0;
      coef_q       <= COEF_RST;
      dout_q       <= '0;
      tap_q        <= '0;
      ch_q         <= '0;
      res_ch_q     <= '0;
      issue_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_d;
      coef_q       <= coef_d;
      dout_q       <= dout_d;
      tap_q        <= tap_d;
      ch_q         <= ch_d;
      res_ch_q     <= res_ch_d;
      issue_done_q <= issue_done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign data_out  = dout_q;

endmodule
